// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: fixed-latency word array with byte-masked
// writes, one-cycle mem_resp strobe and abort on dropped requests.
module lc3b_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_wmask,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY >= 2 ? LATENCY - 2 : 0);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  resp_q, resp_d;
    logic [15:0]           rdata_q, rdata_d;
    logic [15:0]           mem_q [2**ADDR_WIDTH];

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr_idx;
    logic                  unused_addr;

    assign req         = mem_read | mem_write;
    assign addr_idx    = mem_address[ADDR_WIDTH:1];
    assign unused_addr = ^{mem_address[0], mem_address[15:ADDR_WIDTH+1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d = addr_idx;
                    wr_d  = mem_write;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // a dropped request wins over an expiring counter
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        resp_d  = (state_d == S_RESP);
        rdata_d = rdata_q;
        if (resp_d && !wr_d) begin
            rdata_d = mem_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // write commits on the edge leaving RESP; reset forces state out of RESP
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && wr_q) begin
            if (mem_wmask[0]) mem_q[idx_q][7:0]  <= mem_wdata[7:0];
            if (mem_wmask[1]) mem_q[idx_q][15:8] <= mem_wdata[15:8];
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: vector table, hand-written corner cases and
// random traffic checked against a word/byte-valid memory model.
module tb_lc3b_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_wdata;
    logic [15:0] rdata3, rdata1;
    logic        resp3, resp1;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl [1024];
    logic [1:0]  kn  [1024];
    logic [15:0] rlast;
    logic [15:0] rlast_m;

    always #5 clk = ~clk;

    lc3b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(rdata3), .mem_resp(resp3)
    );

    lc3b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_resp(resp1)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [1:0]  wm;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp, input logic [15:0] msk);
        checks++;
        if (((act ^ exp) & msk) !== 16'h0000) begin
            errors++;
            $display("FAIL %s got %h want %h (mask %h)", name, act, exp, msk);
        end
    endtask

    function automatic logic resp_of(input int lat);
        return (lat == 1) ? resp1 : resp3;
    endfunction

    function automatic logic [15:0] rdata_of(input int lat);
        return (lat == 1) ? rdata1 : rdata3;
    endfunction

    task automatic req(input int lat, input logic wr, input logic rd,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [1:0] wm, input logic [15:0] exp,
                       input logic [15:0] emsk, input string name,
                       input bit scr);
        @(negedge clk);
        chk({name, "_idle"}, {15'b0, resp_of(lat)}, 16'h0, 16'h1);
        mem_write   = wr;
        mem_read    = rd;
        mem_address = addr;
        mem_wdata   = wd;
        mem_wmask   = wm;
        if (scr && lat > 1) begin
            mem_wdata = 16'($urandom);
            mem_wmask = 2'($urandom);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk({name, "_resp"}, {15'b0, resp_of(lat)},
                {15'b0, 1'(k == lat)}, 16'h1);
            if (k < lat && scr) begin
                mem_address = 16'($urandom);
                if (k < lat - 1) begin
                    mem_wdata = 16'($urandom);
                    mem_wmask = 2'($urandom);
                end else begin
                    mem_wdata = wd;
                    mem_wmask = wm;
                end
            end
        end
        chk({name, "_rdata"}, rdata_of(lat), exp, emsk);
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic mdl_write(input logic [15:0] addr, input logic [15:0] wd,
                             input logic [1:0] wm);
        logic [9:0] idx;
        idx = addr[10:1];
        if (wm[0]) begin
            mdl[idx][7:0] = wd[7:0];
            kn[idx][0]    = 1'b1;
        end
        if (wm[1]) begin
            mdl[idx][15:8] = wd[15:8];
            kn[idx][1]     = 1'b1;
        end
    endtask

    task automatic op3(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] wm,
                       input string name, input bit scr);
        logic [9:0]  idx;
        logic [15:0] exp, emsk;
        idx = addr[10:1];
        if (wr) begin
            exp  = rlast;
            emsk = rlast_m;
        end else begin
            exp  = mdl[idx];
            emsk = {{8{kn[idx][1]}}, {8{kn[idx][0]}}};
        end
        req(3, wr, rd, addr, wd, wm, exp, emsk, name, scr);
        if (wr) begin
            mdl_write(addr, wd, wm);
        end else begin
            rlast   = exp;
            rlast_m = emsk;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'h0040, 16'hBEEF, 2'b11, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 16'h0040, 16'h0000, 2'b00, 16'hBEEF};
        tbl[2]  = '{1'b1, 1'b0, 16'h0010, 16'h1234, 2'b11, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 16'h0010, 16'hAB00, 2'b10, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 2'b00, 16'hAB34};
        tbl[5]  = '{1'b1, 1'b0, 16'h0010, 16'h00CD, 2'b01, 16'h0000};
        tbl[6]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 2'b00, 16'hABCD};
        tbl[7]  = '{1'b1, 1'b0, 16'h0010, 16'hFFFF, 2'b00, 16'h0000};
        tbl[8]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 2'b00, 16'hABCD};
        tbl[9]  = '{1'b1, 1'b0, 16'h0802, 16'hCAFE, 2'b11, 16'h0000};
        tbl[10] = '{1'b0, 1'b1, 16'h0002, 16'h0000, 2'b00, 16'hCAFE};

        for (int i = 0; i < 1024; i++) begin
            mdl[i] = 16'h0000;
            kn[i]  = 2'b00;
        end
        rlast   = 16'h0000;
        rlast_m = 16'hFFFF;

        reset_n     = 1'b0;
        mem_address = 16'h0000;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wmask   = 2'b00;
        mem_wdata   = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp3", {15'b0, resp3}, 16'h0, 16'h1);
        chk("rst_rdata3", rdata3, 16'h0000, 16'hFFFF);
        chk("rst_resp1", {15'b0, resp1}, 16'h0, 16'h1);
        chk("rst_rdata1", rdata1, 16'h0000, 16'hFFFF);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            op3(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].wm,
                $sformatf("vec%0d", i), 1'b0);
            if (!tbl[i].wr) begin
                chk($sformatf("vec%0d_tbl", i), rdata3, tbl[i].exp, 16'hFFFF);
            end
        end

        // abort a read after one WAIT cycle
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 16'h0040;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("abort_rd_resp", {15'b0, resp3}, 16'h0, 16'h1);
            mem_read = 1'b0;
        end
        op3(1'b1, 1'b0, 16'h0040, 16'h1357, 2'b11, "post_abort_wr", 1'b0);

        // abort a write in the last WAIT cycle: array must stay untouched
        @(negedge clk);
        mem_write   = 1'b1;
        mem_address = 16'h0040;
        mem_wdata   = 16'h0000;
        mem_wmask   = 2'b11;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("abort_wr_resp", {15'b0, resp3}, 16'h0, 16'h1);
            if (k == 2) mem_write = 1'b0;
        end
        op3(1'b0, 1'b1, 16'h0040, 16'h0, 2'b00, "abort_wr_rd", 1'b0);

        // held write across mem_resp becomes a second request
        @(negedge clk);
        mem_write   = 1'b1;
        mem_address = 16'h0020;
        mem_wdata   = 16'h4444;
        mem_wmask   = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("b2b_resp", {15'b0, resp3},
                {15'b0, 1'(k == 3 || k == 7)}, 16'h1);
        end
        mem_write = 1'b0;
        mdl_write(16'h0020, 16'h4444, 2'b11);
        op3(1'b0, 1'b1, 16'h0020, 16'h0, 2'b00, "b2b_rd", 1'b0);

        // reset in WAIT of a write
        op3(1'b0, 1'b1, 16'h0040, 16'h0, 2'b00, "pre_rst_rd", 1'b0);
        @(negedge clk);
        mem_write   = 1'b1;
        mem_address = 16'h0040;
        mem_wdata   = 16'h9999;
        mem_wmask   = 2'b11;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_resp", {15'b0, resp3}, 16'h0, 16'h1);
        chk("rst_wait_rdata", rdata3, 16'h0000, 16'hFFFF);
        mem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rlast   = 16'h0000;
        rlast_m = 16'hFFFF;
        op3(1'b0, 1'b1, 16'h0040, 16'h0, 2'b00, "rst_wait_rd", 1'b0);

        // reset in RESP of a write
        @(negedge clk);
        mem_write   = 1'b1;
        mem_address = 16'h0040;
        mem_wdata   = 16'h8888;
        mem_wmask   = 2'b11;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        chk("rst_resp_pre", {15'b0, resp3}, 16'h1, 16'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_resp_resp", {15'b0, resp3}, 16'h0, 16'h1);
        chk("rst_resp_rdata", rdata3, 16'h0000, 16'hFFFF);
        mem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rlast   = 16'h0000;
        rlast_m = 16'hFFFF;
        op3(1'b0, 1'b1, 16'h0040, 16'h0, 2'b00, "rst_resp_rd", 1'b0);

        // random traffic with aliasing, mid-request scrambling and aborts
        for (int n = 0; n < 60; n++) begin
            logic        wr, rd;
            logic [15:0] addr;
            int          kab;
            wr   = 1'($urandom);
            rd   = wr ? 1'($urandom) : 1'b1;
            addr = 16'($urandom) & 16'hF81F;
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                mem_write   = 1'b1;
                mem_read    = 1'b0;
                mem_address = addr;
                mem_wdata   = 16'($urandom);
                mem_wmask   = 2'b11;
                kab = $urandom_range(1, 2);
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    chk("rnd_abort_resp", {15'b0, resp3}, 16'h0, 16'h1);
                    if (k == kab) mem_write = 1'b0;
                end
            end else begin
                op3(wr, rd, addr, 16'($urandom), 2'($urandom),
                    $sformatf("rnd%0d", n), 1'b1);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // LATENCY=1 instance: timing, write priority, rdata hold
        req(1, 1'b1, 1'b0, 16'h0060, 16'h1111, 2'b11, 16'h0, 16'h0,
            "l1_wr", 1'b0);
        req(1, 1'b0, 1'b1, 16'h0060, 16'h0, 2'b00, 16'h1111, 16'hFFFF,
            "l1_rd", 1'b0);
        req(1, 1'b1, 1'b1, 16'h0060, 16'h2222, 2'b11, 16'h1111, 16'hFFFF,
            "l1_both", 1'b0);
        req(1, 1'b0, 1'b1, 16'h0060, 16'h0, 2'b00, 16'h2222, 16'hFFFF,
            "l1_raw", 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_mem_responder.md
# lc3b_mem_responder

Memory-side responder for the LC-3b datapath memory interface. It accepts the `mem_read` / `mem_write` strobes, the address and the write data driven by the datapath. After a fixed, parameterised latency it returns read data and a one-cycle `mem_resp`. It backs the datapath in simulation and FPGA bring-up with a word-organised on-chip array that supports byte-masked writes.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: number of word-address bits. The array holds 2^ADDR_WIDTH 16-bit words.
- `LATENCY`, default 3: cycles from request acceptance to `mem_resp`. Legal range 1..15.

Ports:
- `clk`  in  1  sole clock. All state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_address`  in  16  byte address. Bit 0 is ignored for word selection. Word index is `mem_address[ADDR_WIDTH:1]`; higher bits are ignored, so addresses alias.
- `mem_read`  in  1  read request. Held high by the requester until `mem_resp`.
- `mem_write`  in  1  write request. Held high by the requester until `mem_resp`.
- `mem_wmask`  in  2  byte enables. Bit 0 enables `[7:0]`; bit 1 enables `[15:8]`.
- `mem_wdata`  in  16  write data.
- `mem_rdata`  out  16  read data. Valid while `mem_resp`=1 for a read.
- `mem_resp`  out  1  completion strobe. High for exactly one cycle per completed request.

## Operation
- FSM states: IDLE, WAIT, RESP. A 4-bit down-counter `cnt` times the WAIT state.
- **IDLE**
  - A request is present when `mem_read | mem_write` is high.
  - If a request is present: capture the word index and the op (write wins if both are high).
  - If `LATENCY`==1, go to RESP. Otherwise go to WAIT and load `cnt` = `LATENCY`-2.
- **WAIT**
  - If the request drops (`mem_read`=`mem_write`=0): abort. Return to IDLE with no response and no array update.
  - Otherwise, if `cnt`==0, go to RESP; else decrement `cnt`.
- **Read data capture**
  - On the edge that enters RESP for a read, `mem_rdata` <= array[index].
  - `mem_rdata` holds its value in all other cycles, including write responses.
- **RESP**
  - `mem_resp`=1 (registered output). Next state is always IDLE.
  - For a write, the array update happens on the edge that ends RESP. It uses the `mem_wdata` and `mem_wmask` present in that cycle.
  - `mem_wmask`=2'b00 completes normally with no data change.
- **Back-to-back requests**
  - The requester must drop or change the request in the cycle after `mem_resp`.
  - A request still high in the following IDLE cycle is treated as a new request.
- **Address/op changes mid-request**
  - Address and op are captured once, in IDLE.
  - Changes to `mem_address` during WAIT are ignored.
  - `mem_wdata` and `mem_wmask` are sampled only at the RESP-exit edge.
- **Reset**
  - `reset_n` low forces IDLE, `cnt`=0, `mem_resp`=0, `mem_rdata`=16'h0000 immediately.
  - Reset mid-WAIT or mid-RESP cancels the request; no write is performed.
  - Array contents are not reset; they are undefined until written.

## Timing
- Request first seen in IDLE in cycle t0; `mem_resp` is high in cycle t0+`LATENCY`.
- Minimum request-to-request spacing is `LATENCY`+1 cycles, since the responder spends one IDLE cycle per request.
- Read-after-write to the same word: the read issued in the cycle after the write's `mem_resp` returns the new data.
- `mem_resp` and `mem_rdata` come directly from flops; there is no combinational input-to-output path.
- Reset deassertion is synchronised externally; the first request may be accepted in the first cycle after `reset_n` rises.

## Test plan
- LATENCY=3. Write 16'hBEEF to 16'h0040 with mask 2'b11, then read 16'h0040 -> each request gets `mem_resp` in cycle t0+3; the read returns 16'hBEEF.
- Byte masks. Write 16'h1234 to 16'h0010 (mask 11), then write 16'hAB00 with mask 10 -> read returns 16'hAB34. Write 16'h00CD with mask 01 -> read returns 16'hABCD. Mask 00 -> data unchanged, `mem_resp` still pulses.
- Abort. Raise `mem_read` at 16'h0040, drop it after 1 cycle -> no `mem_resp`, FSM back in IDLE. A following write with the request held and mask 11 still completes in 3 cycles.
- Back-to-back. Hold `mem_write` across `mem_resp` -> a second response arrives at t0+3+1+3. With ADDR_WIDTH=10, write 16'h0802 (alias of 16'h0002) then read 16'h0002 -> aliased data returned.
- LATENCY=1 and simultaneous `mem_read` and `mem_write` -> `mem_resp` in cycle t0+1 and the write is performed (write priority). `mem_rdata` is unchanged from its prior value.
- Assert `reset_n`=0 in the WAIT cycle of a write -> `mem_resp`=0 and `mem_rdata`=16'h0000 immediately; a later read of that address shows the old contents.
